// File: rtl/mips_core_pkg.sv
// Shared core types for the branch prediction / resolution path.
//   ADDR_WIDTH           : default PC / target width
//   BranchOutcome        : branch direction (NOT_TAKEN / TAKEN)
//   branch_track_entry_t : one in-flight prediction record kept at execute
package mips_core_pkg;

    localparam int ADDR_WIDTH = 32;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        BranchOutcome          prediction;
        logic [ADDR_WIDTH-1:0] recovery_target;
    } branch_track_entry_t;

endpackage

// File: rtl/branch_track_fifo.sv
// In-order storage for in-flight branch records with head/tail/count.
//   push / wdata    : write at tail, advance tail
//   pop             : advance head (oldest entry consumed)
//   squash_younger  : drop everything after head, consuming head as well
//   flush           : return to the empty, zero-pointer state
//   head_data       : entry at head (combinational read)
//   head/tail/count : pointers and occupancy (count is 0..DEPTH)
// Entry storage is deliberately not reset; only pointers are.
module branch_track_fifo #(
    parameter int DEPTH    = 4,
    parameter int DATA_W   = 8,
    parameter int TAG_BITS = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                pop,
    input  logic                squash_younger,
    input  logic                flush,
    output logic [DATA_W-1:0]   head_data,
    output logic [TAG_BITS-1:0] head,
    output logic [TAG_BITS-1:0] tail,
    output logic [TAG_BITS:0]   count
);

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [TAG_BITS-1:0] head_q, head_d, tail_q, tail_d;
    logic [TAG_BITS:0]   count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (squash_younger) begin
            // The mispredicted head is resolved; everything behind it is wrong-path.
            head_d  = head_q + TAG_BITS'(1);
            tail_d  = head_q + TAG_BITS'(1);
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + TAG_BITS'(1);
            if (pop)  head_d = head_q + TAG_BITS'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (TAG_BITS+1)'(1);
                2'b01:   count_d = count_q - (TAG_BITS+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= wdata;
    end

    assign head_data = mem_q[head_q];
    assign head      = head_q;
    assign tail      = tail_q;
    assign count     = count_q;

endmodule

// File: rtl/branch_resolve_tracker.sv
// Execute-side branch tracker: records decode predictions in order, checks
// them against actual outcomes, feeds the predictor and redirects on a miss.
//   i_alloc_*   : decode-side allocation; o_alloc_ready / o_alloc_tag back
//   i_res_*     : execute resolves the oldest branch (tag must equal head)
//   i_flush     : discard all tracked branches
//   o_fb_*      : one-cycle feedback pulse to the predictor (registered)
//   o_recover_* : one-cycle mispredict redirect (registered)
//   o_count     : tracked entries; o_err : protocol error pulse
module branch_resolve_tracker
    import mips_core_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = mips_core_pkg::ADDR_WIDTH,
    parameter int TAG_BITS   = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_alloc_valid,
    input  logic [ADDR_WIDTH-1:0] i_alloc_pc,
    input  logic                  i_alloc_prediction,
    input  logic [ADDR_WIDTH-1:0] i_alloc_recovery_target,
    output logic                  o_alloc_ready,
    output logic [TAG_BITS-1:0]   o_alloc_tag,
    input  logic                  i_res_valid,
    input  logic [TAG_BITS-1:0]   i_res_tag,
    input  logic                  i_res_outcome,
    input  logic                  i_flush,
    output logic                  o_fb_valid,
    output logic [ADDR_WIDTH-1:0] o_fb_pc,
    output logic                  o_fb_prediction,
    output logic                  o_fb_outcome,
    output logic                  o_recover_valid,
    output logic [ADDR_WIDTH-1:0] o_recover_target,
    output logic [TAG_BITS:0]     o_count,
    output logic                  o_err
);

    localparam int DATA_W = $bits(branch_track_entry_t);

    branch_track_entry_t wr_entry, head_entry;
    logic [DATA_W-1:0]   head_data;
    logic [TAG_BITS-1:0] head, tail;
    logic [TAG_BITS:0]   count;
    logic not_full, res_ok, mispredict, push, pop, squash, err_now;

    logic                  fb_valid_q, fb_valid_d, fb_pred_q, fb_pred_d, fb_out_q, fb_out_d;
    logic [ADDR_WIDTH-1:0] fb_pc_q, fb_pc_d, rec_target_q, rec_target_d;
    logic                  rec_valid_q, rec_valid_d, err_q, err_d;

    always_comb begin
        wr_entry.pc              = i_alloc_pc;
        wr_entry.prediction      = BranchOutcome'(i_alloc_prediction);
        wr_entry.recovery_target = i_alloc_recovery_target;
    end

    assign head_entry = branch_track_entry_t'(head_data);
    assign not_full   = (count != (TAG_BITS+1)'(DEPTH));

    // Only the oldest entry may resolve; anything else is a protocol error.
    assign res_ok     = i_res_valid && (count != '0) && (i_res_tag == head);
    assign mispredict = res_ok && (BranchOutcome'(i_res_outcome) != head_entry.prediction);

    // Allocations alongside a mispredict or flush are wrong-path: dropped, no error.
    assign push    = i_alloc_valid && not_full && !mispredict && !i_flush;
    assign pop     = res_ok;
    assign squash  = mispredict && !i_flush;
    assign err_now = (i_res_valid && !res_ok)
                   || (i_alloc_valid && !not_full && !mispredict && !i_flush);

    branch_track_fifo #(
        .DEPTH    (DEPTH),
        .DATA_W   (DATA_W),
        .TAG_BITS (TAG_BITS)
    ) u_fifo (
        .clk            (clk),
        .rst            (rst),
        .push           (push),
        .wdata          (wr_entry),
        .pop            (pop),
        .squash_younger (squash),
        .flush          (i_flush),
        .head_data      (head_data),
        .head           (head),
        .tail           (tail),
        .count          (count)
    );

    always_comb begin
        fb_valid_d   = res_ok;
        fb_pc_d      = fb_pc_q;
        fb_pred_d    = fb_pred_q;
        fb_out_d     = fb_out_q;
        rec_valid_d  = squash;
        rec_target_d = rec_target_q;
        err_d        = err_now;
        if (res_ok) begin
            fb_pc_d   = head_entry.pc;
            fb_pred_d = head_entry.prediction;
            fb_out_d  = i_res_outcome;
        end
        if (squash) rec_target_d = head_entry.recovery_target;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fb_valid_q   <= 1'b0;
            fb_pc_q      <= '0;
            fb_pred_q    <= 1'b0;
            fb_out_q     <= 1'b0;
            rec_valid_q  <= 1'b0;
            rec_target_q <= '0;
            err_q        <= 1'b0;
        end else begin
            fb_valid_q   <= fb_valid_d;
            fb_pc_q      <= fb_pc_d;
            fb_pred_q    <= fb_pred_d;
            fb_out_q     <= fb_out_d;
            rec_valid_q  <= rec_valid_d;
            rec_target_q <= rec_target_d;
            err_q        <= err_d;
        end
    end

    // Ready is held low while reset is asserted so every output reads 0 then.
    assign o_alloc_ready    = not_full && !rst;
    assign o_alloc_tag      = tail;
    assign o_fb_valid       = fb_valid_q;
    assign o_fb_pc          = fb_pc_q;
    assign o_fb_prediction  = fb_pred_q;
    assign o_fb_outcome     = fb_out_q;
    assign o_recover_valid  = rec_valid_q;
    assign o_recover_target = rec_target_q;
    assign o_count          = count;
    assign o_err            = err_q;

endmodule

// File: tb/tb_branch_resolve_tracker.sv
module tb_branch_resolve_tracker;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int TB    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_alloc_valid, i_alloc_prediction, i_res_valid, i_res_outcome, i_flush;
    logic [AW-1:0] i_alloc_pc, i_alloc_recovery_target;
    logic [TB-1:0] i_res_tag;
    logic          o_alloc_ready, o_fb_valid, o_fb_prediction, o_fb_outcome, o_recover_valid, o_err;
    logic [TB-1:0] o_alloc_tag;
    logic [AW-1:0] o_fb_pc, o_recover_target;
    logic [TB:0]   o_count;

    branch_resolve_tracker #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .TAG_BITS(TB)) dut (
        .clk(clk), .rst(rst),
        .i_alloc_valid(i_alloc_valid), .i_alloc_pc(i_alloc_pc),
        .i_alloc_prediction(i_alloc_prediction),
        .i_alloc_recovery_target(i_alloc_recovery_target),
        .o_alloc_ready(o_alloc_ready), .o_alloc_tag(o_alloc_tag),
        .i_res_valid(i_res_valid), .i_res_tag(i_res_tag), .i_res_outcome(i_res_outcome),
        .i_flush(i_flush),
        .o_fb_valid(o_fb_valid), .o_fb_pc(o_fb_pc), .o_fb_prediction(o_fb_prediction),
        .o_fb_outcome(o_fb_outcome), .o_recover_valid(o_recover_valid),
        .o_recover_target(o_recover_target), .o_count(o_count), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        i_alloc_valid = 1'b0; i_alloc_pc = '0; i_alloc_prediction = 1'b0;
        i_alloc_recovery_target = '0; i_res_valid = 1'b0; i_res_tag = '0;
        i_res_outcome = 1'b0; i_flush = 1'b0;
    endtask

    // ---------------- reference model (queue of in-flight branches) ----------------
    typedef struct {
        logic [AW-1:0] pc;
        logic          pred;
        logic [AW-1:0] rt;
    } ment_t;

    ment_t         mq[$];
    int            mhead;
    logic          e_fbv, e_fbp, e_fbo, e_recv, e_err;
    logic [AW-1:0] e_fbpc, e_rect;

    task automatic model_reset();
        mq.delete(); mhead = 0;
        e_fbv = 0; e_fbp = 0; e_fbo = 0; e_recv = 0; e_err = 0; e_fbpc = '0; e_rect = '0;
    endtask

    task automatic model_step();
        bit rdy, ok, mis;
        rdy = (mq.size() != DEPTH);
        ok  = i_res_valid && (mq.size() > 0) && (i_res_tag == TB'(mhead));
        mis = 0;
        if (ok) mis = (i_res_outcome != mq[0].pred);
        e_fbv  = ok;
        e_recv = mis && !i_flush;
        e_err  = (i_res_valid && !ok) || (i_alloc_valid && !rdy && !mis && !i_flush);
        if (ok) begin
            e_fbpc = mq[0].pc; e_fbp = mq[0].pred; e_fbo = i_res_outcome;
        end
        if (e_recv) e_rect = mq[0].rt;
        if (i_flush) begin
            mq.delete(); mhead = 0;
        end else if (mis) begin
            mq.delete(); mhead = (mhead + 1) % DEPTH;
        end else begin
            if (ok) begin
                void'(mq.pop_front());
                mhead = (mhead + 1) % DEPTH;
            end
            if (i_alloc_valid && rdy)
                mq.push_back('{i_alloc_pc, i_alloc_prediction, i_alloc_recovery_target});
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          av;  logic [AW-1:0] pc; logic pred; logic [AW-1:0] rt;
        logic          rv;  logic [TB-1:0] tag; logic out; logic fl;
        logic          efbv; logic [AW-1:0] efbpc; logic efbp;
        logic          erv; logic [AW-1:0] ert; logic eerr;
        logic [TB:0]   ecnt; logic erdy; logic [TB-1:0] etag;
    } vec_t;

    vec_t tbl[17];

    initial begin
        //          av pc     pr rt      rv tag out fl  fbv fbpc  fbp rv rt     err cnt rdy tag
        tbl[0]  = '{1, 'h100, 1, 'h108, 0, 0, 0, 0,  0, 0,     0,  0, 0,     0,  1,  1,  1};
        tbl[1]  = '{0, 0,     0, 0,     1, 0, 1, 0,  1, 'h100, 1,  0, 0,     0,  0,  1,  1};
        tbl[2]  = '{1, 'h100, 0, 'h140, 0, 0, 0, 0,  0, 0,     0,  0, 0,     0,  1,  1,  2};
        tbl[3]  = '{1, 'h200, 0, 'h240, 0, 0, 0, 0,  0, 0,     0,  0, 0,     0,  2,  1,  3};
        tbl[4]  = '{1, 'h300, 0, 'h340, 0, 0, 0, 0,  0, 0,     0,  0, 0,     0,  3,  1,  0};
        tbl[5]  = '{0, 0,     0, 0,     1, 1, 1, 0,  1, 'h100, 0,  1, 'h140, 0,  0,  1,  2};
        tbl[6]  = '{0, 0,     0, 0,     1, 2, 1, 0,  0, 0,     0,  0, 0,     1,  0,  1,  2};
        tbl[7]  = '{1, 'h400, 1, 'h440, 0, 0, 0, 0,  0, 0,     0,  0, 0,     0,  1,  1,  3};
        tbl[8]  = '{1, 'h500, 1, 'h540, 0, 0, 0, 0,  0, 0,     0,  0, 0,     0,  2,  1,  0};
        tbl[9]  = '{1, 'h600, 1, 'h640, 0, 0, 0, 0,  0, 0,     0,  0, 0,     0,  3,  1,  1};
        tbl[10] = '{1, 'h700, 1, 'h740, 0, 0, 0, 0,  0, 0,     0,  0, 0,     0,  4,  0,  2};
        tbl[11] = '{1, 'h800, 1, 'h840, 0, 0, 0, 0,  0, 0,     0,  0, 0,     1,  4,  0,  2};
        tbl[12] = '{1, 'h900, 1, 'h940, 1, 2, 1, 0,  1, 'h400, 1,  0, 0,     1,  3,  1,  2};
        tbl[13] = '{1, 'ha00, 1, 'ha40, 1, 3, 1, 0,  1, 'h500, 1,  0, 0,     0,  3,  1,  3};
        tbl[14] = '{0, 0,     0, 0,     1, 2, 1, 0,  0, 0,     0,  0, 0,     1,  3,  1,  3};
        tbl[15] = '{1, 'hb00, 1, 'hb40, 1, 0, 0, 1,  1, 'h600, 1,  0, 0,     0,  0,  1,  0};
        tbl[16] = '{0, 0,     0, 0,     0, 0, 0, 0,  0, 0,     0,  0, 0,     0,  0,  1,  0};
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        #2;
        chk("rst_count",  32'(o_count), 0);
        chk("rst_ready",  32'(o_alloc_ready), 0);
        chk("rst_fbv",    32'(o_fb_valid), 0);
        chk("rst_recv",   32'(o_recover_valid), 0);
        chk("rst_err",    32'(o_err), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_ready", 32'(o_alloc_ready), 1);
        chk("rel_tag",   32'(o_alloc_tag), 0);

        // Directed table
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            i_alloc_valid = tbl[i].av; i_alloc_pc = tbl[i].pc;
            i_alloc_prediction = tbl[i].pred; i_alloc_recovery_target = tbl[i].rt;
            i_res_valid = tbl[i].rv; i_res_tag = tbl[i].tag;
            i_res_outcome = tbl[i].out; i_flush = tbl[i].fl;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_fbv", i), 32'(o_fb_valid), 32'(tbl[i].efbv));
            if (tbl[i].efbv) begin
                chk($sformatf("v%0d_fbpc", i),   o_fb_pc, tbl[i].efbpc);
                chk($sformatf("v%0d_fbpred", i), 32'(o_fb_prediction), 32'(tbl[i].efbp));
                chk($sformatf("v%0d_fbout", i),  32'(o_fb_outcome), 32'(tbl[i].out));
            end
            chk($sformatf("v%0d_recv", i), 32'(o_recover_valid), 32'(tbl[i].erv));
            if (tbl[i].erv) chk($sformatf("v%0d_rect", i), o_recover_target, tbl[i].ert);
            chk($sformatf("v%0d_err", i),   32'(o_err), 32'(tbl[i].eerr));
            chk($sformatf("v%0d_count", i), 32'(o_count), 32'(tbl[i].ecnt));
            chk($sformatf("v%0d_ready", i), 32'(o_alloc_ready), 32'(tbl[i].erdy));
            chk($sformatf("v%0d_tag", i),   32'(o_alloc_tag), 32'(tbl[i].etag));
        end

        // Reset asserted mid-operation while a feedback pulse is live
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            i_alloc_valid = 1'b1; i_alloc_pc = 32'h1000 + 32'(i) * 32'h10;
            i_alloc_prediction = 1'b1; i_alloc_recovery_target = 32'h2000;
        end
        @(negedge clk);
        idle_inputs();
        i_res_valid = 1'b1; i_res_tag = '0; i_res_outcome = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_fbv_pre",   32'(o_fb_valid), 1);
        chk("mid_count_pre", 32'(o_count), 3);
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("mid_count", 32'(o_count), 0);
        chk("mid_fbv",   32'(o_fb_valid), 0);
        chk("mid_recv",  32'(o_recover_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rel_ready", 32'(o_alloc_ready), 1);
        chk("mid_rel_tag",   32'(o_alloc_tag), 0);

        // Randomized run against the queue model
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            i_alloc_valid = ($urandom_range(0, 99) < 60);
            i_alloc_pc = $urandom;
            i_alloc_prediction = 1'($urandom);
            i_alloc_recovery_target = $urandom;
            i_res_valid = ($urandom_range(0, 99) < 45);
            i_res_tag = ($urandom_range(0, 9) == 0) ? TB'($urandom) : TB'(mhead);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) i_res_outcome = mq[0].pred;
            else i_res_outcome = 1'($urandom);
            i_flush = ($urandom_range(0, 99) < 3);
            #1;
            chk("rnd_ready", 32'(o_alloc_ready), 32'(mq.size() != DEPTH));
            chk("rnd_tag",   32'(o_alloc_tag), 32'((mhead + mq.size()) % DEPTH));
            model_step();
            @(posedge clk);
            #1;
            chk("rnd_fbv",   32'(o_fb_valid), 32'(e_fbv));
            chk("rnd_fbpc",  o_fb_pc, e_fbpc);
            chk("rnd_fbp",   32'(o_fb_prediction), 32'(e_fbp));
            chk("rnd_fbo",   32'(o_fb_outcome), 32'(e_fbo));
            chk("rnd_recv",  32'(o_recover_valid), 32'(e_recv));
            chk("rnd_rect",  o_recover_target, e_rect);
            chk("rnd_err",   32'(o_err), 32'(e_err));
            chk("rnd_count", 32'(o_count), 32'(mq.size()));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
